obi_wb_responder_bridge: RTL

//  OBI responder facing a core LSU/fetch port (req/gnt/rvalid); Wishbone classic initiator toward the Controller memory.

---
 rtl/obi_wb_responder_bridge.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/obi_wb_responder_bridge.sv
// OBI responder to Wishbone classic initiator bridge with one outstanding access.
// Optional bus-wait timeout is built when OBI_WB_TIMEOUT_EN is defined.
module obi_wb_responder_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      obi_req_i,
    output logic                      obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]     obi_addr_i,
    input  logic                      obi_we_i,
    input  logic [DATA_WIDTH/8-1:0]   obi_be_i,
    input  logic [DATA_WIDTH-1:0]     obi_wdata_i,
    output logic                      obi_rvalid_o,
    output logic [DATA_WIDTH-1:0]     obi_rdata_o,
    output logic                      obi_err_o,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
    output logic [ADDR_WIDTH-1:0]     wb_addr_o,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    input  logic                      wb_ack_i,
    input  logic                      wb_err_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_r;
    logic                    cyc_r;
    logic                    we_r;
    logic [BE_WIDTH-1:0]     sel_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic                    rvalid_r;
    logic                    err_r;
    logic [DATA_WIDTH-1:0]   rdata_r;

    logic                    grant_s;
    logic                    term_s;
    logic                    term_err_s;
    logic                    timeout_s;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("obi_wb_responder_bridge: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef OBI_WB_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_r;

    assign timeout_s = (tmo_cnt_r == TMO_LAST);

    // Bus-wait counter: cleared at grant, advances each unterminated BUS cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt_r <= '0;
        end else if (grant_s) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == BUS) && !term_s) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Grant decode and bus-phase termination; an ack on the expiry cycle beats the timeout
    always_comb begin
        grant_s    = 1'b0;
        term_s     = 1'b0;
        term_err_s = 1'b0;
        if (state_r == IDLE) begin
            grant_s = obi_req_i;
        end else begin
            grant_s = 1'b0;
        end
        if (state_r == BUS) begin
            term_s     = wb_ack_i | wb_err_i | timeout_s;
            term_err_s = wb_err_i | (timeout_s & ~wb_ack_i);
        end else begin
            term_s     = 1'b0;
            term_err_s = 1'b0;
        end
    end

    // Transaction FSM: latch request at grant, run one WB cycle, pulse the response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cyc_r    <= 1'b0;
            we_r     <= 1'b0;
            sel_r    <= '0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                    if (grant_s) begin
                        state_r <= BUS;
                        cyc_r   <= 1'b1;
                        we_r    <= obi_we_i;
                        sel_r   <= obi_be_i;
                        addr_r  <= obi_addr_i;
                        wdata_r <= obi_wdata_i;
                    end
                end
                BUS: begin
                    if (term_s) begin
                        state_r  <= RESP;
                        cyc_r    <= 1'b0;
                        rvalid_r <= 1'b1;
                        err_r    <= term_err_s;
                        // Only a clean read ack refreshes the returned data
                        if (!we_r && wb_ack_i && !term_err_s) begin
                            rdata_r <= wb_dat_i;
                        end
                    end
                end
                RESP: begin
                    state_r  <= IDLE;
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    cyc_r    <= 1'b0;
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                end
            endcase
        end
    end

    assign obi_gnt_o    = grant_s;
    assign obi_rvalid_o = rvalid_r;
    assign obi_err_o    = err_r;
    assign obi_rdata_o  = rdata_r;
    assign wb_cyc_o     = cyc_r;
    assign wb_stb_o     = cyc_r;
    assign wb_we_o      = we_r;
    assign wb_sel_o     = sel_r;
    assign wb_addr_o    = addr_r;
    assign wb_dat_o     = wdata_r;

endmodule
